// File: rtl/seg_pkg.sv
// Shared types and constants for the 3-digit 7-segment scan controller.
// Includes the double-dabble step helper used by the conversion engine.
package seg_pkg;

    localparam int          NUM_DIGITS     = 3;
    localparam int          BCD_W          = 4;
    localparam logic [3:0]  SEG_BLANK_CODE = 4'hF;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } scan_state_t;

    // One double-dabble iteration on the BCD scratch: add 3 to every nibble
    // that is 5 or more, then shift left by one taking bit_in as the new LSB.
    function automatic logic [11:0] dd_step(input logic [11:0] scratch,
                                            input logic        bit_in);
        logic [11:0] adj;
        adj = scratch;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (scratch[n*BCD_W +: BCD_W] >= 4'd5) begin
                adj[n*BCD_W +: BCD_W] = scratch[n*BCD_W +: BCD_W] + 4'd3;
            end
        end
        return {adj[10:0], bit_in};
    endfunction

    // One-hot digit enable for a digit index (bit 0 = units).
    function automatic logic [NUM_DIGITS-1:0] idx_onehot(input digit_idx_t idx);
        logic [NUM_DIGITS-1:0] oh;
        oh = '0;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// SegDecoder: BCD digit to active-high segments a..g on bits 6..0.
// Any code above 9 (including the blank code 4'hF) turns all segments off.
module SegDecoder (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup; registered by the caller together with the digit enable.
    always_comb begin
        seg_o = 7'b0000000;
        case (bcd_i)
            4'd0:    seg_o = 7'b1111110;
            4'd1:    seg_o = 7'b0110000;
            4'd2:    seg_o = 7'b1101101;
            4'd3:    seg_o = 7'b1111001;
            4'd4:    seg_o = 7'b0110011;
            4'd5:    seg_o = 7'b1011011;
            4'd6:    seg_o = 7'b1011111;
            4'd7:    seg_o = 7'b1110000;
            4'd8:    seg_o = 7'b1111111;
            4'd9:    seg_o = 7'b1111011;
            default: seg_o = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: accepts a byte over valid/ready, converts it to three BCD
// digits with a sequential double-dabble engine, and scans the digits on a
// common-bus 3-digit 7-segment display through one shared SegDecoder.
// Optional feature: define SEG_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int DIV_W       = $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [7:0]            load_data,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);

    // Conversion FSM and datapath
    scan_state_t state_q, state_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic [11:0] disp_q, disp_d;

    // Scanner
    logic [DIV_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [3:0]       nib_sel;
    logic [3:0]       dec_in;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_q;
    logic [NUM_DIGITS-1:0] dig_en_q;

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == CONVERT);
    assign seg        = seg_q;
    assign dig_en     = dig_en_q;

    // Next-state logic for the load/convert FSM and its datapath.
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        disp_d    = disp_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shift_d   = load_data;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = dd_step(scratch_q, shift_q[7]);
                shift_d   = {shift_q[6:0], 1'b0};
                iter_d    = iter_q + 3'd1;
                // Last iteration: publish the finished digits in one step so
                // the scanner never sees a half-converted value.
                if (iter_q == 3'd7) begin
                    disp_d  = scratch_d;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible state: FSM, iteration count, display register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
        end
    end

    // Conversion working registers; always reloaded before use, so no reset.
    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        scratch_q <= scratch_d;
    end

    // Dwell counter and digit index advance, free-running.
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Select the displayed nibble and apply optional leading-zero blanking.
    always_comb begin
        nib_sel = disp_q[3:0];
        case (idx_q)
            2'd0:    nib_sel = disp_q[3:0];
            2'd1:    nib_sel = disp_q[7:4];
            2'd2:    nib_sel = disp_q[11:8];
            default: nib_sel = disp_q[3:0];
        endcase
        dec_in = nib_sel;
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (idx_q == 2'd2 && disp_q[11:8] == 4'd0) begin
            dec_in = SEG_BLANK_CODE;
        end
        if (idx_q == 2'd1 && disp_q[11:8] == 4'd0 && disp_q[7:4] == 4'd0) begin
            dec_in = SEG_BLANK_CODE;
        end
`endif
    end

    SegDecoder u_dec (
        .bcd_i (dec_in),
        .seg_o (dec_seg)
    );

    // Scanner state plus output register; seg and dig_en update on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            seg_q    <= 7'b0000000;
            dig_en_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= dec_seg;
            dig_en_q <= idx_onehot(idx_q);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV = 4.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic       load_ready;
    logic       busy;
    logic [6:0] seg;
    logic [2:0] dig_en;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .busy       (busy),
        .seg        (seg),
        .dig_en     (dig_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a given digit to be enabled, then check its segments.
    task automatic check_digit(input string tag, input logic [2:0] en, input logic [6:0] exp_seg);
        int n = 0;
        while (dig_en !== en && n < 16) begin
            step();
            n++;
        end
        check({tag, "_en"}, {5'd0, dig_en}, {5'd0, en});
        check({tag, "_seg"}, {1'b0, seg}, {1'b0, exp_seg});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (load_ready !== 1'b1 && n < 32) begin
            step();
            n++;
        end
    endtask

    // Wait (bounded) for busy to drop; returns cycles counted from handshake.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 32) begin
            step();
            cycles++;
        end
    endtask

    task automatic do_load(input logic [7:0] v, output int cycles);
        wait_ready();
        load_valid = 1'b1;
        load_data  = v;
        step();
        load_valid = 1'b0;
        wait_idle(cycles);
        step();
    endtask

    initial begin
        int         bc;
        int         run;
        int         changes;
        bit         ok_onehot;
        bit         ok_seq;
        logic [2:0] prev;
        logic [6:0] lead_seg;

        // Reset held
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_seg", {1'b0, seg}, 8'b0000_0000);
        check("rst_dig_en", {5'd0, dig_en}, 8'd0);
        check("rst_ready", {7'd0, load_ready}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);

        // First edge after release shows units digit of 000
        rst_n = 1'b1;
        step();
        check("first_dig_en", {5'd0, dig_en}, 8'b001);
        check("first_seg", {1'b0, seg}, 8'b0111_1110);

        // Scan cadence: 4-cycle dwell, rotation 001->010->100->001
        run = 1;
        changes = 0;
        ok_onehot = 1'b1;
        ok_seq = 1'b1;
        prev = dig_en;
        for (int i = 0; i < 24; i++) begin
            step();
            if (!$onehot(dig_en)) ok_onehot = 1'b0;
            if (dig_en !== prev) begin
                if (run != 4) ok_seq = 1'b0;
                if (dig_en !== {prev[1:0], prev[2]}) ok_seq = 1'b0;
                changes++;
                run = 1;
                prev = dig_en;
            end else begin
                run++;
            end
        end
        check("scan_onehot", {7'd0, ok_onehot}, 8'd1);
        check("scan_dwell_order", {7'd0, ok_seq}, 8'd1);
        check("scan_changes", 8'(changes), 8'd6);

        // Load 255 -> "255"
        do_load(8'd255, bc);
        check("busy_cycles_255", 8'(bc), 8'd8);
        check_digit("v255_units", 3'b001, 7'b1011011);
        check_digit("v255_tens", 3'b010, 7'b1011011);
        check_digit("v255_hund", 3'b100, 7'b1101101);

        // Load 128, attempt 99 while busy -> ignored
        wait_ready();
        load_valid = 1'b1;
        load_data  = 8'd128;
        step();
        load_valid = 1'b0;
        step();
        step();
        load_valid = 1'b1;
        load_data  = 8'd99;
        check("busy_ready_low", {7'd0, load_ready}, 8'd0);
        check("busy_high", {7'd0, busy}, 8'd1);
        step();
        load_valid = 1'b0;
        wait_idle(bc);
        step();
        check("ready_after_128", {7'd0, load_ready}, 8'd1);
        step();
        check("no_capture_99", {7'd0, busy}, 8'd0);
        check_digit("v128_units", 3'b001, 7'b1111111);
        check_digit("v128_tens", 3'b010, 7'b1101101);
        check_digit("v128_hund", 3'b100, 7'b0110000);

        // Load 7 -> "007" or blanked leading zeros
`ifdef SEG_SCAN_LZ_BLANK_EN
        lead_seg = 7'b0000000;
`else
        lead_seg = 7'b1111110;
`endif
        do_load(8'd7, bc);
        check_digit("v7_units", 3'b001, 7'b1110000);
        check_digit("v7_tens", 3'b010, lead_seg);
        check_digit("v7_hund", 3'b100, lead_seg);

        // Load 42, reset during the fourth iteration
        wait_ready();
        load_valid = 1'b1;
        load_data  = 8'd42;
        step();
        load_valid = 1'b0;
        repeat (4) step();
        check("midconv_busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_seg", {1'b0, seg}, 8'd0);
        check("midrst_dig_en", {5'd0, dig_en}, 8'd0);
        check("midrst_busy", {7'd0, busy}, 8'd0);
        check("midrst_ready", {7'd0, load_ready}, 8'd1);
        step();
        rst_n = 1'b1;
        step();
        check("postrst_dig_en", {5'd0, dig_en}, 8'b001);
        check("postrst_seg", {1'b0, seg}, 8'b0111_1110);
        check_digit("postrst_tens", 3'b010, 7'b1111110);
        check_digit("postrst_hund", 3'b100, 7'b1111110);
        check("postrst_ready", {7'd0, load_ready}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
